// File: rtl/irq_prio_encoder_if.sv
// ---------------------------------------------------------------------------
// irq_prio_encoder_if
// Request/grant bundle for irq_prio_encoder.
//   S    : enable, active-high (driven by requester side)
//   NI   : N active-low request lines, synchronous to the encoder clock
//   ACK  : grant acknowledge, active-high
//   Y    : active-low grant code (all ones while no grant is valid)
//   VLD  : grant valid, active-high
//   YS   : active-low "enabled, nothing pending" (cascade enable-out)
//   YEX  : active-low "enabled, something pending" (group select)
//   PEND : pending vector, active-high (debug)
// Modports: master = requester/host side, slave = encoder side.
// ---------------------------------------------------------------------------
interface irq_prio_encoder_if #(
  parameter int N = 8,
  parameter int W = (N > 2) ? $clog2(N) : 1
);
  logic         S;
  logic [N-1:0] NI;
  logic         ACK;
  logic [W-1:0] Y;
  logic         VLD;
  logic         YS;
  logic         YEX;
  logic [N-1:0] PEND;

  modport master (
    output S, NI, ACK,
    input  Y, VLD, YS, YEX, PEND
  );

  modport slave (
    input  S, NI, ACK,
    output Y, VLD, YS, YEX, PEND
  );
endinterface

// File: rtl/irq_prio_encoder.sv
// ---------------------------------------------------------------------------
// irq_prio_encoder
// Registered, parametrised priority encoder in the spirit of the 74148.
// Falling edges on the active-low request lines are captured into a pending
// register; an IDLE/GRANT FSM arbitrates among pending channels (fixed
// priority with index N-1 highest, or round-robin) and presents the winner
// as an active-low code under a VLD/ACK handshake. YS/YEX keep the 148-style
// cascade behaviour so several encoders can still be chained.
// Ports:
//   CLK  : clock, all state on the rising edge
//   NRST : asynchronous active-low reset
//   bus  : irq_prio_encoder_if.slave (S, NI, ACK in; Y, VLD, YS, YEX, PEND out)
// Parameters:
//   N  : number of request channels (>= 2)
//   RR : 0 = fixed priority, 1 = round-robin
// ---------------------------------------------------------------------------
module irq_prio_encoder #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input  logic                 CLK,
  input  logic                 NRST,
  irq_prio_encoder_if.slave    bus
);

  localparam int W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q,   state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] ni_prev_q, ni_prev_d;
  logic [W-1:0] grant_q,   grant_d;
  logic [W-1:0] ptr_q,     ptr_d;
  logic         arm_q,     arm_d;

  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic [W-1:0] winner;
  logic         vld;

  // Highest set index wins.
  function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] req);
    pick_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) pick_fixed = W'(i);
    end
  endfunction

  // Search downward from start, wrapping N-1 -> 0; first set bit wins.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] req,
                                           input logic [W-1:0] start);
    logic found;
    int   idx;
    pick_rr = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) - k + N) % N;
      if (!found && req[idx]) begin
        pick_rr = W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    winner = (RR != 0) ? pick_rr(pending_q, ptr_q) : pick_fixed(pending_q);
  end

  // arm_q blocks capture on the first edge after reset release, so lines that
  // were already low while in reset are only resampled, not seen as edges.
  always_comb begin
    arm_d     = 1'b1;
    ni_prev_d = bus.NI;
    set_mask  = (bus.S && arm_q) ? (ni_prev_q & ~bus.NI) : '0;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (bus.S && (pending_q != '0)) begin
          grant_d = winner;
          ptr_d   = (winner == '0) ? W'(N - 1) : winner - W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Losing enable aborts the grant but keeps the request pending.
        if (!bus.S) begin
          state_d = IDLE;
        end else if (bus.ACK) begin
          clr_mask[grant_q] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Set is applied after clear so a coincident new edge survives the ACK.
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ni_prev_q <= '1;
      grant_q   <= '0;
      ptr_q     <= W'(N - 1);
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ni_prev_q <= ni_prev_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      arm_q     <= arm_d;
    end
  end

  assign vld      = (state_q == GRANT);
  assign bus.VLD  = vld;
  assign bus.Y    = vld ? ~grant_q : '1;
  assign bus.YEX  = ~(bus.S & (|pending_q));
  assign bus.YS   = ~(bus.S & ~(|pending_q));
  assign bus.PEND = pending_q;

endmodule

// File: tb/tb_irq_prio_encoder.sv
// ---------------------------------------------------------------------------
// tb_irq_prio_encoder
// Directed, table-driven bench for irq_prio_encoder. One instance in fixed
// priority mode, one in round-robin mode, both N=8 sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_irq_prio_encoder;

  logic CLK;
  logic NRST;

  irq_prio_encoder_if #(.N(8)) if0 ();
  irq_prio_encoder_if #(.N(8)) if1 ();

  irq_prio_encoder #(.N(8), .RR(0)) dut0 (.CLK(CLK), .NRST(NRST), .bus(if0.slave));
  irq_prio_encoder #(.N(8), .RR(1)) dut1 (.CLK(CLK), .NRST(NRST), .bus(if1.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       s;
    logic [7:0] ni;
    logic       ack;
    logic       vld;
    logic [2:0] y;
    logic       ys;
    logic       yex;
    logic [7:0] pend;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t tbl0[25];
  vec_t tbl1[11];

  function automatic vec_t mk(input logic s, input logic [7:0] ni, input logic ack,
                              input logic vld, input logic [2:0] y, input logic ys,
                              input logic yex, input logic [7:0] pend);
    vec_t r;
    r.s = s; r.ni = ni; r.ack = ack; r.vld = vld;
    r.y = y; r.ys = ys; r.yex = yex; r.pend = pend;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk0(input string tag, input logic vld, input logic [2:0] y,
                      input logic ys, input logic yex, input logic [7:0] pend);
    chk({tag, " VLD"},  32'(if0.VLD),  32'(vld));
    chk({tag, " Y"},    32'(if0.Y),    32'(y));
    chk({tag, " YS"},   32'(if0.YS),   32'(ys));
    chk({tag, " YEX"},  32'(if0.YEX),  32'(yex));
    chk({tag, " PEND"}, 32'(if0.PEND), 32'(pend));
  endtask

  task automatic chk1(input string tag, input logic vld, input logic [2:0] y,
                      input logic ys, input logic yex, input logic [7:0] pend);
    chk({tag, " VLD"},  32'(if1.VLD),  32'(vld));
    chk({tag, " Y"},    32'(if1.Y),    32'(y));
    chk({tag, " YS"},   32'(if1.YS),   32'(ys));
    chk({tag, " YEX"},  32'(if1.YEX),  32'(yex));
    chk({tag, " PEND"}, 32'(if1.PEND), 32'(pend));
  endtask

  initial begin
    //                s     NI     ACK   VLD   Y     YS    YEX   PEND
    tbl0[0]  = mk(1'b1, 8'hFF, 1'b0, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00); // idle
    tbl0[1]  = mk(1'b1, 8'hDB, 1'b0, 1'b0, 3'h7, 1'b1, 1'b0, 8'h24); // 2,5 fall
    tbl0[2]  = mk(1'b1, 8'hDB, 1'b0, 1'b1, 3'h2, 1'b1, 1'b0, 8'h24); // grant 5
    tbl0[3]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'h7, 1'b1, 1'b0, 8'h04); // ack -> gap
    tbl0[4]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h5, 1'b1, 1'b0, 8'h04); // grant 2
    tbl0[5]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    tbl0[6]  = mk(1'b1, 8'hF7, 1'b0, 1'b0, 3'h7, 1'b1, 1'b0, 8'h08); // 3 falls
    tbl0[7]  = mk(1'b1, 8'hF7, 1'b0, 1'b1, 3'h4, 1'b1, 1'b0, 8'h08); // grant 3
    tbl0[8]  = mk(1'b1, 8'hF7, 1'b1, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00); // held low
    tbl0[9]  = mk(1'b1, 8'hF7, 1'b0, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00); // no retrigger
    tbl0[10] = mk(1'b1, 8'hF7, 1'b0, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    tbl0[11] = mk(1'b1, 8'hFF, 1'b0, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00); // release
    tbl0[12] = mk(1'b1, 8'hF7, 1'b0, 1'b0, 3'h7, 1'b1, 1'b0, 8'h08); // new fall
    tbl0[13] = mk(1'b1, 8'hF7, 1'b0, 1'b1, 3'h4, 1'b1, 1'b0, 8'h08);
    tbl0[14] = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    tbl0[15] = mk(1'b1, 8'hEF, 1'b0, 1'b0, 3'h7, 1'b1, 1'b0, 8'h10); // 4 falls
    tbl0[16] = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h3, 1'b1, 1'b0, 8'h10); // grant 4
    tbl0[17] = mk(1'b0, 8'hFF, 1'b0, 1'b0, 3'h7, 1'b1, 1'b1, 8'h10); // S abort
    tbl0[18] = mk(1'b0, 8'hFF, 1'b0, 1'b0, 3'h7, 1'b1, 1'b1, 8'h10);
    tbl0[19] = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h3, 1'b1, 1'b0, 8'h10); // regrant 4
    tbl0[20] = mk(1'b1, 8'hEF, 1'b1, 1'b0, 3'h7, 1'b1, 1'b0, 8'h10); // collision
    tbl0[21] = mk(1'b1, 8'hEF, 1'b0, 1'b1, 3'h3, 1'b1, 1'b0, 8'h10);
    tbl0[22] = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    tbl0[23] = mk(1'b1, 8'hEF, 1'b0, 1'b0, 3'h7, 1'b1, 1'b0, 8'h10);
    tbl0[24] = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h3, 1'b1, 1'b0, 8'h10); // mid-grant

    // Round-robin: 7 and 6 re-pulsed on every ACK cycle.
    tbl1[0]  = mk(1'b1, 8'h3F, 1'b0, 1'b0, 3'h7, 1'b1, 1'b0, 8'hC0);
    tbl1[1]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h0, 1'b1, 1'b0, 8'hC0); // 7
    tbl1[2]  = mk(1'b1, 8'h7F, 1'b1, 1'b0, 3'h7, 1'b1, 1'b0, 8'hC0);
    tbl1[3]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h1, 1'b1, 1'b0, 8'hC0); // 6
    tbl1[4]  = mk(1'b1, 8'hBF, 1'b1, 1'b0, 3'h7, 1'b1, 1'b0, 8'hC0);
    tbl1[5]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h0, 1'b1, 1'b0, 8'hC0); // 7
    tbl1[6]  = mk(1'b1, 8'h7F, 1'b1, 1'b0, 3'h7, 1'b1, 1'b0, 8'hC0);
    tbl1[7]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h1, 1'b1, 1'b0, 8'hC0); // 6
    tbl1[8]  = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'h7, 1'b1, 1'b0, 8'h80);
    tbl1[9]  = mk(1'b1, 8'hFF, 1'b0, 1'b1, 3'h0, 1'b1, 1'b0, 8'h80); // 7
    tbl1[10] = mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);

    NRST = 1'b0;
    if0.S = 1'b1; if0.NI = 8'hFF; if0.ACK = 1'b0;
    if1.S = 1'b1; if1.NI = 8'hFF; if1.ACK = 1'b0;
    #12;
    chk0("reset", 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    @(negedge CLK);
    NRST = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if0.S = tbl0[i].s; if0.NI = tbl0[i].ni; if0.ACK = tbl0[i].ack;
      step();
      chk0($sformatf("fp[%0d]", i), tbl0[i].vld, tbl0[i].y, tbl0[i].ys,
           tbl0[i].yex, tbl0[i].pend);
    end

    // Reset asserted mid-grant: outputs drop without waiting for a clock.
    #2 NRST = 1'b0;
    #1;
    chk0("async_rst", 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    if0.NI = 8'hEF;
    @(negedge CLK);
    NRST = 1'b1;
    step();
    chk0("post_rst1", 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    step();
    chk0("post_rst2", 1'b0, 3'h7, 1'b0, 1'b1, 8'h00);
    if0.NI = 8'hFF;
    step();
    if0.NI = 8'hEF;
    step();
    chk0("post_rst_edge", 1'b0, 3'h7, 1'b1, 1'b0, 8'h10);
    step();
    chk0("post_rst_grant", 1'b1, 3'h3, 1'b1, 1'b0, 8'h10);

    for (int i = 0; i < 11; i++) begin
      if1.S = tbl1[i].s; if1.NI = tbl1[i].ni; if1.ACK = tbl1[i].ack;
      step();
      chk1($sformatf("rr[%0d]", i), tbl1[i].vld, tbl1[i].y, tbl1[i].ys,
           tbl1[i].yex, tbl1[i].pend);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_prio_encoder.md
# irq_prio_encoder

Parametrised, registered successor to the team's 8-to-3 priority encoder. Captures falling edges on N active-low request lines into a pending register and arbitrates among them, fixed-priority (highest index wins) or round-robin. The winning channel is presented as an active-low binary code under a valid/acknowledge handshake. Keeps the 74148-style enable input and cascade outputs (YS, YEX) so several instances can still be chained.

## Interface
- N, default 8: number of request channels, N ≥ 2; code width W = max(1, clog2(N)).
- RR, default 0: arbitration mode; 0 = fixed priority (index N-1 highest), 1 = round-robin.

Ports:
- CLK  in  1  clock; all state on rising edge.
- NRST  in  1  reset; asynchronous, active-low.
- S  in  1  enable, active-high.
- NI  in  N  active-low requests, synchronous to CLK.
- ACK  in  1  grant acknowledge, active-high.
- Y  out  W  active-low grant code.
- VLD  out  1  grant valid, active-high.
- YS  out  1  active-low "enabled, nothing pending" (cascade enable-out).
- YEX  out  1  active-low "enabled, something pending" (group select).
- PEND  out  N  pending vector, active-high (debug).

## Operation
- Edge capture:
  - NI_q holds the previous NI sample.
  - pending[i] is set at an edge where S=1, NI_q[i]=1 and NI[i]=0.
  - A level held low sets the bit only once.
  - NI_q updates every cycle regardless of S.
  - With S=0 no new bits are set; existing bits are held.
- FSM states: IDLE, GRANT.
  - IDLE: if S=1 and pending≠0, register winner g into grant, set VLD=1, go to GRANT.
  - GRANT: grant and Y are held stable.
    - ACK=1: clear pending[g], VLD=0, go to IDLE.
    - S=0 (checked before ACK): VLD=0, go to IDLE, pending[g] retained.
- Arbitration:
  - RR=0: highest-index set bit.
  - RR=1: search downward starting at ptr, wrapping N-1 → 0. On each grant ptr ← (g-1) mod N. Reset value ptr = N-1, so the first arbitration equals fixed priority.
- Set/clear collision: a new falling edge on channel g in the same cycle as ACK leaves pending[g]=1 (set wins).
- ACK while VLD=0 is ignored.
- Y = ~grant while VLD=1, otherwise all ones. Codes ≥ N are never produced (N need not be a power of two).
- Cascade outputs (combinational from S and the pending register):
  - YEX = ~(S & |pending).
  - YS = ~(S & ~|pending).
  - With S=0 all of Y, YS and YEX are high, as in the original 148.
- PEND = pending.

## Timing
- Reset (asynchronous, immediate):
  - pending=0, NI_q=all ones, state IDLE, grant=0, ptr=N-1.
  - VLD=0, Y=all ones, PEND=0, YEX=1, YS=~S.
- Request to grant: falling edge sampled at edge t sets pending after t; YEX goes low after t; VLD=1 with Y valid after t+1. Latency is 2 edges.
- Acknowledge: ACK sampled at edge a drops VLD after a. The next grant (if pending) asserts after a+1, so there is exactly one VLD-low cycle between grants.
- Y changes only on edges where VLD rises or falls.
- Reset asserted mid-grant: VLD drops asynchronously and all pending requests are lost. The first edge after release only resamples NI into NI_q (lines already low do not register an edge).

## Test plan
- Idle (N=8, RR=0): reset; S=1, NI=8'hFF -> VLD=0, Y=3'b111, YS=0, YEX=1, PEND=0.
- Fixed-priority ordering (N=8, RR=0): NI bits 2 and 5 fall together -> two edges later VLD=1, Y=3'b010. ACK -> one gap cycle, then Y=3'b101. ACK -> VLD=0, YEX=1, YS=0.
- No level retrigger: NI[3] held low through grant and ACK -> no second grant. NI[3] released then falls again -> new grant with Y=3'b100.
- Round-robin (RR=1): NI[7] and NI[6] re-pulsed before every ACK -> grant sequence 7,6,7,6 (Y=000,001,000,001).
- Enable abort: S deasserted during GRANT on channel 4 -> next edge VLD=0, Y=111, YS=YEX=1, PEND[4]=1. S reasserted -> channel 4 granted again.
- Collision and reset: ACK of channel 4 coincides with a new NI[4] falling edge -> PEND[4] stays 1 and channel 4 is regranted. NRST pulsed low mid-grant -> VLD=0, PEND=0 immediately.
